uart_tx_fsm: RTL

UART transmitter: serialises one parallel byte per request into a frame of start bit, 8 data bits LSB first, optional parity bit and one stop bit on `tx_out`. Each bit is held for `prescale` clock cycles, the same parameterised bit-time scheme the receive path uses. It sits between the host-side byte source and the serial line, and pairs with the UART receiver on the far end.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_fsm_if.sv | 23 ++
 rtl/tx_bit_timer.sv | 39 +++
 rtl/uart_tx_fsm.sv | 105 ++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path: FSM state encodings,
// parity selection and frame sizes.
package uart_tx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR   = 11;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Host-side request bus and serial output of the UART transmitter.
interface uart_tx_fsm_if #(
  parameter int PWIDTH = 6,
  parameter int DWIDTH = 8
);
  logic [PWIDTH-1:0] prescale;
  logic [DWIDTH-1:0] p_data;
  logic              data_valid;
  logic              parity_en;
  logic              parity_type;
  logic              tx_out;
  logic              busy;

  modport master (
    output prescale, p_data, data_valid, parity_en, parity_type,
    input  tx_out, busy
  );

  modport slave (
    input  prescale, p_data, data_valid, parity_en, parity_type,
    output tx_out, busy
  );
endinterface

// File: rtl/tx_bit_timer.sv
// Bit-time counter: edge_cnt runs 0..P-1 inside each serial bit, bit_cnt
// indexes the data bit and only advances while bit_en is set.
module tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int PWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              bit_en,
  input  logic [PWIDTH-1:0] p_eff,
  output logic              bit_done,
  output logic [2:0]        bit_cnt
);

  logic [PWIDTH-1:0] edge_cnt;
  logic [PWIDTH-1:0] p_last;

  // p_eff is never 0 while running, so p_last cannot underflow there
  assign p_last   = p_eff - PWIDTH'(1);
  assign bit_done = (edge_cnt == p_last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (bit_done) begin
        edge_cnt <= '0;
        if (bit_en) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        edge_cnt <= edge_cnt + PWIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// one stop bit; each bit held for max(prescale,1) clock cycles.
//
//   state  | meaning
//   IDLE   | line high, not busy, waiting for data_valid
//   START  | line low for one bit time
//   DATA   | captured byte shifted out LSB first
//   PARITY | parity of captured byte, even or odd as captured
//   STOP   | line high for one bit time, then back to IDLE
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int PWIDTH = 6,
  parameter int DWIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fsm_if.slave  bus
);

  localparam logic [2:0] LAST_BIT = 3'(DWIDTH - 1);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [DWIDTH-1:0] data_q;
  logic [PWIDTH-1:0] p_q;
  logic              par_en_q;
  logic              par_type_q;
  logic              tx_q;
  logic              busy_q;
  logic              tx_nx;
  logic              accept;
  logic              timer_run;
  logic              bit_done;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_nx;
  logic              par_bit;

  assign accept    = (state == IDLE) && bus.data_valid;
  assign timer_run = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
  assign par_bit   = (^data_q) ^ (par_type_q == ODD);

  tx_bit_timer #(.PWIDTH(PWIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!timer_run),
    .enable   (timer_run),
    .bit_en   (state == DATA),
    .p_eff    (p_q),
    .bit_done (bit_done),
    .bit_cnt  (bit_cnt)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)   state_nx = START;
      START:   if (bit_done) state_nx = DATA;
      DATA:    if (bit_done && (bit_cnt == LAST_BIT))
                 state_nx = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_nx = STOP;
      STOP:    if (bit_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tx_out is registered, so the mux looks at the state being entered
  always_comb begin
    bit_nx = ((state == DATA) && bit_done) ? bit_cnt + 3'd1 : bit_cnt;
    tx_nx  = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = data_q[bit_nx];
      PARITY:  tx_nx = par_bit;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      data_q     <= '0;
      p_q        <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
    end else begin
      state  <= state_nx;
      tx_q   <= tx_nx;
      busy_q <= (state_nx != IDLE);
      if (accept) begin
        data_q     <= bus.p_data;
        p_q        <= (bus.prescale == '0) ? PWIDTH'(1) : bus.prescale;
        par_en_q   <= bus.parity_en;
        par_type_q <= bus.parity_type;
      end
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule
